// File: rtl/serdes_pkg.sv
// Shared definitions for the 1x/4x sync tracker and the QPI serializing gearbox.
package serdes_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam int PHASE_W   = 2;
    localparam int ERR_CNT_W = 8;
    // LOCK_COUNT and ERR_MAX are limited to 1..15, so 4 bits hold good/miss.
    localparam int CNT_W     = 4;

endpackage

// File: rtl/serdes_sync_track.sv
// Locks onto the 1-in-4 sync strobe, tracks the slow-cycle phase and counts
// sync errors seen while locked.
module serdes_sync_track
    import serdes_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_MAX    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sync,
    output logic [PHASE_W-1:0]   o_phase,
    output logic                 o_locked,
    output logic                 o_capture_en,
    output logic                 o_err_pulse,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output sync_state_t          o_state
);

    localparam logic [CNT_W:0] LOCK_TGT = LOCK_COUNT[CNT_W:0];
    localparam logic [CNT_W:0] ERR_TGT  = ERR_MAX[CNT_W:0];

    sync_state_t           r_state;
    sync_state_t           w_state_nxt;
    logic [PHASE_W-1:0]    r_phase;
    logic [PHASE_W-1:0]    w_phase_nxt;
    logic [CNT_W-1:0]      r_good;
    logic [CNT_W-1:0]      w_good_nxt;
    logic [CNT_W-1:0]      r_miss;
    logic [CNT_W-1:0]      w_miss_nxt;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic                  r_err_pulse;
    logic                  w_err;
    logic                  w_at_slot;
    logic                  w_expected;
    logic                  w_missing;
    logic                  w_unexpected;
    logic [CNT_W:0]        w_good_inc;
    logic [CNT_W:0]        w_miss_inc;

    assign w_at_slot    = (r_phase == 2'd3);
    assign w_expected   = w_at_slot && i_sync;
    assign w_missing    = w_at_slot && !i_sync;
    assign w_unexpected = !w_at_slot && i_sync;
    assign w_good_inc   = {1'b0, r_good} + 5'd1;
    assign w_miss_inc   = {1'b0, r_miss} + 5'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + 2'd1;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_err       = 1'b0;
        case (r_state)
            HUNT: begin
                if (i_sync) begin
                    w_phase_nxt = '0;
                    w_good_nxt  = 4'd1;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (w_expected) begin
                    w_good_nxt = w_good_inc[CNT_W-1:0];
                    if (w_good_inc == LOCK_TGT) begin
                        w_state_nxt = LOCKED;
                        w_miss_nxt  = '0;
                    end
                end else if (w_missing) begin
                    w_state_nxt = HUNT;
                    w_good_nxt  = '0;
                end else if (w_unexpected) begin
                    w_phase_nxt = '0;
                    w_good_nxt  = 4'd1;
                end
            end
            LOCKED: begin
                // Phase is never touched here: a stray sync must not drag the lanes.
                if (w_expected) begin
                    w_miss_nxt = '0;
                end else if (w_missing || w_unexpected) begin
                    w_err = 1'b1;
                    if (w_miss_inc >= ERR_TGT) begin
                        w_state_nxt = HUNT;
                        w_good_nxt  = '0;
                        w_miss_nxt  = '0;
                    end else begin
                        w_miss_nxt = w_miss_inc[CNT_W-1:0];
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_phase     <= '0;
            r_good      <= '0;
            r_miss      <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_good      <= w_good_nxt;
            r_miss      <= w_miss_nxt;
            r_err_pulse <= w_err;
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign o_phase      = r_phase;
    assign o_locked     = (r_state == LOCKED);
    assign o_capture_en = o_locked && w_at_slot;
    assign o_err_pulse  = r_err_pulse;
    assign o_err_cnt    = r_err_cnt;
    assign o_state      = r_state;

endmodule

// File: rtl/serdes_sync_gearbox.sv
// Serializes one 4-lane slow-domain word into one DW-bit lane per fast clock,
// aligned to the tracked sync phase.
module serdes_sync_gearbox
    import serdes_pkg::*;
#(
    parameter int DW         = 4,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_MAX    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync,
    input  logic [4*DW-1:0]      in_data,
    input  logic                 in_valid,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    output logic [PHASE_W-1:0]   out_phase,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [PHASE_W-1:0] w_phase;
    logic               w_locked;
    logic               w_capture_en;
    sync_state_t        w_state;
    logic [4*DW-1:0]    r_hold;
    logic               r_hold_valid;
    logic [DW-1:0]      w_lane;

    serdes_sync_track #(
        .LOCK_COUNT (LOCK_COUNT),
        .ERR_MAX    (ERR_MAX)
    ) u_track (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sync       (sync),
        .o_phase      (w_phase),
        .o_locked     (w_locked),
        .o_capture_en (w_capture_en),
        .o_err_pulse  (err_pulse),
        .o_err_cnt    (err_cnt),
        .o_state      (w_state)
    );

    // Flushing the holding register outside LOCKED keeps a stale word from
    // reappearing after relock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_capture_en) begin
            r_hold       <= in_data;
            r_hold_valid <= in_valid;
        end else if (w_state != LOCKED) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end
    end

    always_comb begin
        w_lane = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_phase == k[PHASE_W-1:0]) begin
                w_lane = r_hold[k*DW +: DW];
            end
        end
    end

    assign out_data  = w_locked ? w_lane : '0;
    assign out_valid = w_locked && r_hold_valid;
    assign out_phase = w_phase;
    assign locked    = w_locked;

endmodule

// File: tb/tb_serdes_sync_gearbox.sv
// Self-checking bench for serdes_sync_gearbox: slot-based sync driver, lane
// scoreboard, lock/error expectations derived from the stimulus schedule.
module tb_serdes_sync_gearbox;
  import serdes_pkg::*;

  localparam int DW         = 4;
  localparam int LOCK_COUNT = 4;
  localparam int ERR_MAX    = 2;
  localparam int W          = 2 + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            sync = 1'b0;
  logic [4*DW-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic [1:0]      out_phase;
  logic            locked;
  logic            err_pulse;
  logic [7:0]      err_cnt;

  serdes_sync_gearbox #(
    .DW         (DW),
    .LOCK_COUNT (LOCK_COUNT),
    .ERR_MAX    (ERR_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_phase (out_phase),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  int pulses_seen = 0;
  int exp_pulses = 0;
  int exp_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_lane;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every valid lane must match the oldest expected {phase, lane}
  always @(negedge clk) begin
    if (err_pulse) pulses_seen++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_lane = exp_q.pop_front();
        check("lane", 32'({out_phase, out_data}), 32'(exp_lane));
      end
    end
  end

  // driver tasks
  task automatic step(input logic s, input logic [4*DW-1:0] d, input logic v);
    sync     = s;
    in_data  = d;
    in_valid = v;
    @(posedge clk);
    #2;
  endtask

  // One slow cycle: mask[k] drives sync on cycle k; cycle 3 is the expected slot.
  task automatic slot(input logic [3:0] mask, input logic [4*DW-1:0] w, input logic v,
                      input int n_lanes);
    for (int k = 0; k < n_lanes; k++) exp_q.push_back({2'(k), w[k*DW +: DW]});
    for (int k = 0; k < 4; k++) step(mask[k], w, v);
  endtask

  task automatic acquire();
    for (int i = 1; i <= LOCK_COUNT; i++) begin
      slot(4'b1000, 16'($urandom), 1'b1, 0);
      check("lock_seq", 32'(locked), 32'(i == LOCK_COUNT));
    end
  endtask

  task automatic err_inc();
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    exp_pulses++;
  endtask

  initial begin
    int n_idle;

    // reset
    repeat (3) step(1'b0, '0, 1'b0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_phase", 32'(out_phase), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;

    // lock acquisition at a random offset
    n_idle = $urandom_range(3, 9);
    repeat (n_idle) step(1'b0, '0, 1'b0);
    acquire();

    // serialization
    slot(4'b1000, 16'hDCBA, 1'b1, 4);
    for (int i = 0; i < 3; i++) slot(4'b1000, 16'($urandom), 1'b1, 4);
    slot(4'b1000, 16'($urandom), 1'b0, 0);
    slot(4'b1000, 16'($urandom), 1'b1, 4);
    check("pulses_after_serial", 32'(pulses_seen), 32'(exp_pulses));

    // single missing sync: word still captured, lock held
    slot(4'b0000, 16'($urandom), 1'b1, 4);
    err_inc();
    check("miss1_locked", 32'(locked), 32'd1);
    check("miss1_pulse", 32'(err_pulse), 32'd1);
    check("miss1_err_cnt", 32'(err_cnt), 32'(exp_err));
    slot(4'b1000, 16'($urandom), 1'b1, 4);
    check("miss1_pulse_clear", 32'(err_pulse), 32'd0);

    // stray sync while locked must not move the phase
    slot(4'b1010, 16'($urandom), 1'b1, 4);
    err_inc();
    check("stray_locked", 32'(locked), 32'd1);
    check("stray_err_cnt", 32'(err_cnt), 32'(exp_err));
    slot(4'b0000, 16'($urandom), 1'b1, 4);
    err_inc();
    check("miss_after_clear_locked", 32'(locked), 32'd1);
    slot(4'b1000, 16'($urandom), 1'b1, 4);

    // loss of lock after two consecutive misses
    slot(4'b0000, 16'($urandom), 1'b1, 4);
    err_inc();
    check("loss_first_locked", 32'(locked), 32'd1);
    slot(4'b0000, 16'($urandom), 1'b1, 0);
    err_inc();
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_out_valid", 32'(out_valid), 32'd0);
    check("loss_out_data", 32'(out_data), 32'd0);
    check("loss_err_cnt", 32'(err_cnt), 32'(exp_err));

    // relock at a new offset
    repeat (2) step(1'b0, '0, 1'b0);
    acquire();

    // lock lost mid-word by a stray sync; it must not seed acquisition
    slot(4'b1000, 16'($urandom), 1'b1, 4);
    slot(4'b0000, 16'($urandom), 1'b1, 2);
    err_inc();
    step(1'b0, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    err_inc();
    check("midword_locked", 32'(locked), 32'd0);
    check("midword_out_valid", 32'(out_valid), 32'd0);
    check("midword_err_cnt", 32'(err_cnt), 32'(exp_err));
    acquire();

    // CHECK resync: no error reporting, good count restarts
    slot(4'b0000, '0, 1'b0, 0);
    err_inc();
    slot(4'b0000, '0, 1'b0, 0);
    err_inc();
    check("pre_check_locked", 32'(locked), 32'd0);
    slot(4'b1000, '0, 1'b0, 0);
    slot(4'b1000, '0, 1'b0, 0);
    step(1'b0, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    check("resync_locked", 32'(locked), 32'd0);
    for (int i = 1; i < LOCK_COUNT; i++) begin
      slot(4'b1000, 16'($urandom), 1'b1, 0);
      check("resync_lock_seq", 32'(locked), 32'(i == LOCK_COUNT - 1));
    end
    check("resync_pulses", 32'(pulses_seen), 32'(exp_pulses));

    // error counter saturation
    repeat (300) begin
      slot(4'b0000, '0, 1'b0, 0);
      err_inc();
      slot(4'b1000, '0, 1'b0, 0);
    end
    check("sat_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("sat_locked", 32'(locked), 32'd1);
    check("sat_pulses", 32'(pulses_seen), 32'(exp_pulses));

    // reset mid-word: only lane 0 escapes before the reset edge
    slot(4'b1000, 16'($urandom), 1'b1, 1);
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0);
    check("mrst_out_data", 32'(out_data), 32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_phase", 32'(out_phase), 32'd0);
    check("mrst_locked", 32'(locked), 32'd0);
    check("mrst_err_pulse", 32'(err_pulse), 32'd0);
    check("mrst_err_cnt", 32'(err_cnt), 32'd0);
    check("mrst_state", 32'(dut.w_state), 32'(HUNT));
    rst_n = 1'b1;
    exp_err = 0;
    repeat (6) step(1'b0, '0, 1'b0);
    check("post_rst_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("post_rst_locked", 32'(locked), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
